// File: rtl/triroc_sc_controller.sv
// TRIROC slow-control sequencer: RAM image -> MSB-first serial shift, then load_sc pulse.
// Optional readback verification pass enabled by defining TRIROC_SC_READBACK_EN.
module triroc_sc_controller #(
    parameter int WIDTH    = 1256,
    parameter int WORD_W   = 16,
    parameter int CLK_DIV  = 5,
    parameter int RST_CYC  = 8,
    parameter int LOAD_CYC = 8,
    localparam int NWORDS  = (WIDTH + WORD_W - 1) / WORD_W,
    localparam int AW      = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic              ck_sys,
    input  logic              rstb_sys,
    input  logic              start,
    input  logic              cmd,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     cfg_addr,
    output logic              cfg_rd,
    input  logic [WORD_W-1:0] cfg_rdata,
    output logic              ck_sr,
    output logic              sr_in,
    input  logic              sr_out,
    output logic              rstb_sr,
    output logic              select,
    output logic              load_sc,
    output logic              verify_err
);

    localparam int M1   = (CLK_DIV > RST_CYC) ? CLK_DIV : RST_CYC;
    localparam int CMAX = (M1 > LOAD_CYC) ? M1 : LOAD_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(WIDTH + 1);
    localparam int WW   = $clog2(WORD_W + 1);

    localparam logic [CW-1:0] DIV_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] RST_END  = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] LOAD_END = CW'(LOAD_CYC - 1);
    localparam logic [BW-1:0] BIT_END  = BW'(WIDTH);
    localparam logic [WW-1:0] WBIT_END = WW'(WORD_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHRST,
        S_FETCH,
        S_WAIT,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LOAD,
        S_FIN
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WW-1:0]     wbit_q, wbit_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [WORD_W-1:0] src;
    logic              ld_bit;
    logic              busy_q, done_q, rd_q, cksr_q, srin_q;
    logic              rstb_q, load_q, sel_q;
    logic              busy_d, done_d, rd_d, cksr_d, srin_d;
    logic              rstb_d, load_d;
`ifdef TRIROC_SC_READBACK_EN
    logic              pass_q, pass_d;
    logic              verr_q, verr_d;
`else
    logic              unused_sr_out;
    assign unused_sr_out = sr_out;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        wbit_d  = wbit_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        srin_d  = srin_q;
        src     = hold_q;
        ld_bit  = 1'b0;
`ifdef TRIROC_SC_READBACK_EN
        pass_d  = pass_q;
        verr_d  = verr_q;
        // Loopback bit is checked just before the rising edge that consumes it.
        if (pass_q && state_q == S_SHIFT_LO && cnt_q == DIV_END && sr_out != srin_q)
            verr_d = 1'b1;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
`ifdef TRIROC_SC_READBACK_EN
                    verr_d = 1'b0;
                    pass_d = 1'b0;
`endif
                    if (cmd) begin
                        state_d = S_CHRST;
                    end else begin
                        state_d = S_FETCH;
                        bit_d   = '0;
                        wbit_d  = '0;
                        addr_d  = '0;
                    end
                end
            end
            S_CHRST: begin
                if (cnt_q == RST_END) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                src     = cfg_rdata;
                ld_bit  = 1'b1;
                cnt_d   = '0;
                state_d = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (cnt_q == DIV_END) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + BW'(1);
                    state_d = S_SHIFT_HI;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHIFT_HI: begin
                if (cnt_q == DIV_END) begin
                    cnt_d = '0;
                    if (bit_q == BIT_END) begin
`ifdef TRIROC_SC_READBACK_EN
                        if (!pass_q) begin
                            pass_d  = 1'b1;
                            bit_d   = '0;
                            wbit_d  = '0;
                            addr_d  = '0;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_LOAD;
                        end
`else
                        state_d = S_LOAD;
`endif
                    end else if (wbit_q == WBIT_END) begin
                        wbit_d  = '0;
                        addr_d  = addr_q + AW'(1);
                        state_d = S_FETCH;
                    end else begin
                        ld_bit  = 1'b1;
                        state_d = S_SHIFT_LO;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOAD: begin
                if (cnt_q == LOAD_END) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (ld_bit) begin
            srin_d = src[WORD_W-1];
            hold_d = src << 1;
            wbit_d = wbit_q + WW'(1);
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_FIN);
        rd_d   = (state_d == S_FETCH);
        cksr_d = (state_d == S_SHIFT_HI);
        rstb_d = (state_d != S_CHRST);
        load_d = (state_d != S_LOAD);
    end

    always_ff @(posedge ck_sys or negedge rstb_sys) begin
        if (!rstb_sys) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            wbit_q  <= '0;
            addr_q  <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            cksr_q  <= 1'b0;
            srin_q  <= 1'b0;
            rstb_q  <= 1'b1;
            load_q  <= 1'b1;
            sel_q   <= 1'b1;
`ifdef TRIROC_SC_READBACK_EN
            pass_q  <= 1'b0;
            verr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            wbit_q  <= wbit_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            cksr_q  <= cksr_d;
            srin_q  <= srin_d;
            rstb_q  <= rstb_d;
            load_q  <= load_d;
            sel_q   <= 1'b1;
`ifdef TRIROC_SC_READBACK_EN
            pass_q  <= pass_d;
            verr_q  <= verr_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_addr = addr_q;
    assign cfg_rd   = rd_q;
    assign ck_sr    = cksr_q;
    assign sr_in    = srin_q;
    assign rstb_sr  = rstb_q;
    assign select   = sel_q;
    assign load_sc  = load_q;
`ifdef TRIROC_SC_READBACK_EN
    assign verify_err = verr_q;
`else
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_triroc_sc_controller.sv
// Bench for triroc_sc_controller: RAM model, ASIC shift-register model, randomized images.
// Readback cases are compiled in when TRIROC_SC_READBACK_EN is defined.
module tb_triroc_sc_controller;

    localparam int TW  = 20;
    localparam int TWW = 8;
    localparam int NW  = 3;
`ifdef TRIROC_SC_READBACK_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic          ck_sys = 1'b0;
    logic          rstb_sys;
    logic          start, cmd;
    logic          busy, done, cfg_rd;
    logic [1:0]    cfg_addr;
    logic [7:0]    cfg_rdata;
    logic          ck_sr, sr_in, sr_out;
    logic          rstb_sr, select, load_sc, verify_err;

    triroc_sc_controller #(
        .WIDTH(TW), .WORD_W(TWW), .CLK_DIV(2), .RST_CYC(8), .LOAD_CYC(8)
    ) dut (
        .ck_sys(ck_sys), .rstb_sys(rstb_sys), .start(start), .cmd(cmd),
        .busy(busy), .done(done), .cfg_addr(cfg_addr), .cfg_rd(cfg_rd),
        .cfg_rdata(cfg_rdata), .ck_sr(ck_sr), .sr_in(sr_in), .sr_out(sr_out),
        .rstb_sr(rstb_sr), .select(select), .load_sc(load_sc),
        .verify_err(verify_err)
    );

    always #5 ck_sys = ~ck_sys;

    logic [7:0] ram [NW];
    always @(posedge ck_sys)
        if (cfg_rd) cfg_rdata <= (cfg_addr < 2'd3) ? ram[cfg_addr] : 8'h00;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [TW-1:0] img_exp, cap, loop;
    int  edges, bit_bad, load_low, ck_in_load, rst_low, done_cnt;
    int  sel_bad, busy_at_done, cyc, rise_cyc, done_cyc;
    bit  ck_prev, rstb_prev, stuck;

    assign sr_out = loop[TW-1];

    always @(negedge ck_sys) begin
        cyc++;
        if (ck_sr && !ck_prev) begin
            if (sr_in !== img_exp[TW-1-(edges % TW)]) bit_bad++;
            edges++;
            cap  = {cap[TW-2:0], sr_in};
            loop = {loop[TW-2:0], sr_in};
            if (stuck) loop[7] = 1'b0;
        end
        ck_prev = ck_sr;
        if (!load_sc) begin
            load_low++;
            if (ck_sr) ck_in_load++;
        end
        if (!rstb_sr) rst_low++;
        if (rstb_sr && !rstb_prev) rise_cyc = cyc;
        rstb_prev = rstb_sr;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) busy_at_done++;
        end
        if (!select) sel_bad++;
    end

    task automatic tick();
        @(negedge ck_sys);
        #1;
    endtask

    task automatic clr_mon();
        edges = 0; bit_bad = 0; load_low = 0; ck_in_load = 0;
        rst_low = 0; done_cnt = 0; sel_bad = 0; busy_at_done = 0;
        rise_cyc = -100; done_cyc = 0; cap = '0; loop = '0;
    endtask

    function automatic logic [TW-1:0] image();
        logic [NW*TWW-1:0] all;
        all = {ram[0], ram[1], ram[2]};
        return all[NW*TWW-1 -: TW];
    endfunction

    task automatic chk_rst_vec(input string tag);
        chk(tag, {busy, done, cfg_rd, cfg_addr, ck_sr, sr_in, rstb_sr,
                  select, load_sc, verify_err}, 32'b000_00_00_111_0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 1500) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 1500), 32'd1);
        repeat (4) tick();
    endtask

    task automatic run_config(input bit glitch, input bit v_exp);
        int  n = 0;
        bit  g = 0;
        clr_mon();
        img_exp = image();
        start = 1'b1;
        cmd   = 1'b0;
        tick();
        start = 1'b0;
        chk("busy_up", busy, 1);
        while (done_cnt == 0 && n < 1500) begin
            tick();
            n++;
            start = glitch && !g && edges >= 5;
            cmd   = 1'($urandom);
            if (start) g = 1;
        end
        start = 1'b0;
        chk("cfg_timeout", 32'(n < 1500), 32'd1);
        repeat (4) tick();
        chk("edges", edges, PASSES * TW);
        chk("bit_seq", bit_bad, 0);
        chk("asic_reg", cap, img_exp);
        chk("load_len", load_low, 8);
        chk("ck_in_load", ck_in_load, 0);
        chk("done_cnt", done_cnt, 1);
        chk("busy_done", busy_at_done, 0);
        chk("busy_end", busy, 0);
        chk("select", sel_bad, 0);
        chk("verify_err", verify_err, v_exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        stuck = 0; img_exp = '0;
        clr_mon();
        rstb_sys = 1'b0;
        start = 1'b0;
        cmd = 1'b0;
        repeat (3) tick();
        chk_rst_vec("reset_vals");
        rstb_sys = 1'b1;
        tick();

        ram[0] = 8'hA5; ram[1] = 8'h3C; ram[2] = 8'hF0;
        chk("img_ref", image(), 20'hA53CF);
        run_config(0, 0);

        clr_mon();
        start = 1'b1;
        cmd = 1'b1;
        tick();
        start = 1'b0;
        wait_done("chrst_timeout");
        chk("chrst_low", rst_low, 8);
        chk("chrst_edges", edges, 0);
        chk("chrst_done_lag", done_cyc - rise_cyc, 1);
        chk("chrst_done_cnt", done_cnt, 1);
        chk("chrst_no_load", load_low, 0);

        for (int i = 0; i < 5; i++) begin
            for (int w = 0; w < NW; w++) ram[w] = 8'($urandom);
            run_config(i == 1 || i == 3, 0);
        end

        for (int w = 0; w < NW; w++) ram[w] = 8'($urandom);
        clr_mon();
        img_exp = image();
        start = 1'b1;
        cmd = 1'b0;
        tick();
        start = 1'b0;
        n = 0;
        while (edges < 10 && n < 1000) begin
            tick();
            n++;
        end
        chk("abort_reach", 32'(n < 1000), 32'd1);
        rstb_sys = 1'b0;
        #1;
        chk_rst_vec("abort_vals");
        repeat (3) tick();
        chk_rst_vec("abort_hold");
        chk("abort_no_load", load_low, 0);
        chk("abort_no_done", done_cnt, 0);
        rstb_sys = 1'b1;
        tick();
        run_config(0, 0);

`ifdef TRIROC_SC_READBACK_EN
        for (int w = 0; w < NW; w++) ram[w] = 8'($urandom);
        ram[1][3] = 1'b1;
        stuck = 1;
        run_config(0, 1);
        stuck = 0;
        run_config(0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/triroc_sc_controller.md
Name: triroc_sc_controller

Overview:
- Sequences the TRIROC 1256-bit slow-control shift register from the FPGA side.
- Fetches a configuration image word-by-word from a local RAM and generates the serial interface ck_sr, sr_in, rstb_sr, select and load_sc.
- Shifts the image MSB-first, then pulses load_sc so the chip latches its input DACs.
- Sits between the run-control register bank and the ASIC pins.

Parameters:
- WIDTH, 1256, shift-register length in bits.
- WORD_W, 16, configuration RAM word width; image occupies NWORDS = ceil(WIDTH/WORD_W) words.
- CLK_DIV, 5, ck_sys cycles per ck_sr half-period (ck_sr = f_ck_sys/(2*CLK_DIV), must stay < 10 MHz).
- RST_CYC, 8, ck_sys cycles rstb_sr is held low for a reset command.
- LOAD_CYC, 8, ck_sys cycles load_sc is held low after shifting.

Ports:
- ck_sys  in  1  system clock.
- rstb_sys  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe, accepted only when busy=0.
- cmd  in  1  0 = CONFIG (shift and load), 1 = CHIP_RESET (pulse rstb_sr only).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of command.
- cfg_addr  out  $clog2(NWORDS)  RAM word address.
- cfg_rd  out  1  RAM read strobe; data valid on cfg_rdata exactly 1 cycle later.
- cfg_rdata  in  WORD_W  RAM read data.
- ck_sr  out  1  shift clock to ASIC.
- sr_in  out  1  serial data to ASIC.
- sr_out  in  1  serial data from ASIC.
- rstb_sr  out  1  active-low ASIC shift-register reset.
- select  out  1  1 = slow control, 0 = probe/read.
- load_sc  out  1  active-low DAC load.
- verify_err  out  1  sticky readback mismatch flag; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset values: busy=0, done=0, cfg_rd=0, cfg_addr=0, ck_sr=0, sr_in=0, rstb_sr=1, select=1, load_sc=1, verify_err=0, FSM=IDLE. All outputs are registered.
- Reset asserted mid-command aborts immediately to the reset values; no partial load_sc pulse is emitted.
- States: IDLE, CHRST, FETCH, WAIT, SHIFT_LO, SHIFT_HI, LOAD, FIN.
- IDLE:
  - start with busy=0: cmd=1 -> CHRST, cmd=0 -> FETCH with bit counter=0 and word address=0.
  - start while busy=1 is ignored; no queueing.
- CHRST: rstb_sr=0 for RST_CYC cycles, then FIN.
- FETCH: cfg_rd=1 for one cycle, then WAIT.
- WAIT: cfg_rdata is captured into a WORD_W holding register. Word 0 holds image bits [WIDTH-1 -: WORD_W]; bits are sent word MSB first. Then SHIFT_LO.
- SHIFT_LO:
  - On entry, ck_sr=0 and sr_in = next bit.
  - Hold CLK_DIV cycles, then SHIFT_HI.
- SHIFT_HI:
  - ck_sr=1 for CLK_DIV cycles. The ASIC samples sr_in on this rising edge, giving sr_in CLK_DIV cycles of setup and hold.
  - Bit counter increments. The first bit sent ends at ASIC bit WIDTH-1.
  - When the bit counter reaches WIDTH, go to LOAD. When the holding register empties, go to FETCH. Otherwise go to SHIFT_LO.
- Last word: the final word contributes only WIDTH - (NWORDS-1)*WORD_W bits, taken from its MSB end; the remaining low bits are never shifted (for WIDTH=1256, WORD_W=16: 79 words, last word 8 bits).
- Exactly WIDTH rising edges of ck_sr occur per CONFIG command; ck_sr returns to 0 before LOAD.
- LOAD: ck_sr=0 and load_sc=0 for LOAD_CYC cycles, then FIN.
- FIN: done=1 for one cycle, busy=0 the same cycle, then IDLE.
- select=1 throughout all commands.

Optional Feature:
- Macro: TRIROC_SC_READBACK_EN.
- Defined:
  - CONFIG shifts the image twice (2*WIDTH edges, second pass re-fetches from word 0).
  - In the second pass, sr_out is sampled on the last ck_sys cycle of each SHIFT_LO and compared with the bit being driven on sr_in; any mismatch sets verify_err.
  - verify_err clears on the next accepted start.
  - LOAD follows the second pass only.
- Undefined: single pass, no comparison logic, verify_err tied 0.

Test Plan:
- Reset: hold rstb_sys=0 -> every output equals its reset value, including rstb_sr=1, load_sc=1, ck_sr=0.
- CONFIG, WIDTH=20, WORD_W=8, CLK_DIV=2, RAM = {0xA5, 0x3C, 0xF0}:
  - Exactly 20 ck_sr rising edges; sr_in at the edges reads 1010_0101_0011_1100_1111; word 2 low nibble is never sent.
  - Then load_sc=0 for 8 cycles and a done pulse; a model register reads 0xA53CF.
- CHIP_RESET: start with cmd=1 -> rstb_sr=0 for exactly 8 cycles, no ck_sr edges, done 1 cycle after rstb_sr rises.
- start pulsed while busy mid-shift -> ignored; edge count stays 20 and exactly one done pulse.
- rstb_sys pulsed low after edge 10 -> outputs return to reset values immediately with no load_sc pulse. A new start then produces a full 20-edge sequence.
- TRIROC_SC_READBACK_EN with a loopback shift-register model: 40 edges, verify_err=0. With model bit 7 stuck at 0 and image bit 7 = 1: verify_err=1 after done.
